// File: rtl/mul_div_if.sv
// mul_div_if: request/response bundle for the iterative multiply/divide unit.
//   Flush    : synchronous abort of the in-flight operation
//   InValid  : request present          InReady : unit can accept (IDLE only)
//   Funct3   : RV32M operation select
//   Op1/Op2  : rs1/rs2 values, sampled on the accept edge only
//   OutValid : Result valid             OutReady : consumer takes Result
//   Result   : registered result        Busy     : unit not in IDLE
interface mul_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Flush;
  logic                  InValid;
  logic                  InReady;
  logic [2:0]            Funct3;
  logic [DATA_WIDTH-1:0] Op1;
  logic [DATA_WIDTH-1:0] Op2;
  logic                  OutValid;
  logic                  OutReady;
  logic [DATA_WIDTH-1:0] Result;
  logic                  Busy;

  modport master (
    output Flush, InValid, Funct3, Op1, Op2, OutReady,
    input  InReady, OutValid, Result, Busy
  );

  modport slave (
    input  Flush, InValid, Funct3, Op1, Op2, OutReady,
    output InReady, OutValid, Result, Busy
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit (MUL, MULH, MULHSU, MULHU,
// DIV, DIVU, REM, REMU). Works on operand magnitudes: radix-2 shift-add for
// multiply, restoring division for divide, one bit per cycle, followed by a
// single sign-fix cycle. Divide-by-zero and signed overflow bypass iteration.
// Ports:
//   Clk : clock, rising edge
//   Rst : asynchronous active-high reset
//   bus : mul_div_if slave (request in, result out, Flush, Busy)
module mul_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic     Clk,
  input  logic     Rst,
  mul_div_if.slave bus
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // control state (reset)
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         result_q, result_d;

  // datapath state (no reset; always loaded on accept before use)
  logic [2:0]           op_q, op_d;
  logic                 neg_res_q, neg_res_d;   // negate product / quotient
  logic                 neg_rem_q, neg_rem_d;   // negate remainder
  logic                 spec_q, spec_d;         // special case pending
  logic [W-1:0]         spec_res_q, spec_res_d;
  logic [W-1:0]         hi_q, hi_d;             // product high half / remainder
  logic [W-1:0]         lo_q, lo_d;             // multiplier / quotient
  logic [W:0]           dvsr_q, dvsr_d;         // multiplicand / divisor magnitude

  // operand decode at accept
  logic         accept;
  logic         a_signed, b_signed, a_neg, b_neg;
  logic [W:0]   a_ext, b_ext, a_mag, b_mag;
  logic         is_div_in, div_zero, sgn_ovf;

  // iteration and fix-up datapath
  logic [W:0]   mul_add;
  logic [W:0]   div_shift;
  logic         div_ge;
  logic [2*W-1:0] prod_full, prod_s;
  logic [W-1:0] quo_s, rem_s, fix_res;

  assign accept    = bus.InValid && (state_q == IDLE) && !bus.Flush;

  assign a_signed  = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010) ||
                     (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
  assign b_signed  = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b100) ||
                     (bus.Funct3 == 3'b110);
  assign a_neg     = a_signed && bus.Op1[W-1];
  assign b_neg     = b_signed && bus.Op2[W-1];
  // One extra bit so the most-negative value has a representable magnitude.
  assign a_ext     = {a_neg, bus.Op1};
  assign b_ext     = {b_neg, bus.Op2};
  assign a_mag     = a_neg ? -a_ext : a_ext;
  assign b_mag     = b_neg ? -b_ext : b_ext;

  assign is_div_in = bus.Funct3[2];
  assign div_zero  = is_div_in && (bus.Op2 == '0);
  // Only DIV/REM (Funct3[0]==0) can overflow.
  assign sgn_ovf   = is_div_in && !bus.Funct3[0] &&
                     (bus.Op1 == MOST_NEG) && (bus.Op2 == '1);

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift {carry, hi, lo} right by one.
  assign mul_add   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvsr_q[W-1:0]} : '0);

  // Restoring step: partial remainder is always below the divisor, so one
  // trial subtraction of the shifted remainder decides the quotient bit.
  assign div_shift = {hi_q, lo_q[W-1]};
  assign div_ge    = (div_shift >= dvsr_q);

  assign prod_full = {hi_q, lo_q};
  assign prod_s    = neg_res_q ? -prod_full : prod_full;
  assign quo_s     = neg_res_q ? -lo_q : lo_q;
  assign rem_s     = neg_rem_q ? -hi_q : hi_q;

  always_comb begin
    fix_res = quo_s;
    if (spec_q)              fix_res = spec_res_q;
    else if (!op_q[2])       fix_res = (op_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
    else if (op_q[1])        fix_res = rem_s;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    op_d        = op_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    spec_d      = spec_q;
    spec_res_d  = spec_res_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    dvsr_d      = dvsr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d       = bus.Funct3;
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          cnt_d      = CNT_WIDTH'(W);
          hi_d       = '0;
          lo_d       = is_div_in ? a_mag[W-1:0] : b_mag[W-1:0];
          dvsr_d     = is_div_in ? b_mag : a_mag;
          spec_d     = div_zero || sgn_ovf;
          if (div_zero)  spec_res_d = bus.Funct3[1] ? bus.Op1 : '1;
          else           spec_res_d = bus.Funct3[1] ? '0 : bus.Op1;
          // Special cases skip iteration; FIX presents the prepared value.
          state_d    = (div_zero || sgn_ovf) ? FIX : CALC;
        end
      end
      CALC: begin
        if (bus.Flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (!op_q[2]) begin
            hi_d = mul_add[W:1];
            lo_d = {mul_add[0], lo_q[W-1:1]};
          end else begin
            hi_d = div_ge ? (div_shift[W-1:0] - dvsr_q[W-1:0]) : div_shift[W-1:0];
            lo_d = {lo_q[W-2:0], div_ge};
          end
          if (cnt_q == CNT_WIDTH'(1)) state_d = FIX;
        end
      end
      FIX: begin
        if (bus.Flush) begin
          state_d = IDLE;
        end else begin
          result_d    = fix_res;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // Flush and OutReady both end the hold; Flush just wins by default.
        if (bus.Flush || bus.OutReady) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  always_ff @(posedge Clk) begin
    op_q       <= op_d;
    neg_res_q  <= neg_res_d;
    neg_rem_q  <= neg_rem_d;
    spec_q     <= spec_d;
    spec_res_q <= spec_res_d;
    hi_q       <= hi_d;
    lo_q       <= lo_d;
    dvsr_q     <= dvsr_d;
  end

  assign bus.InReady  = !Rst && (state_q == IDLE);
  assign bus.Busy     = (state_q != IDLE);
  assign bus.OutValid = out_valid_q;
  assign bus.Result   = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit (DATA_WIDTH=32).
// The driver pushes the reference result for every issued op; a monitor pops
// and compares on each OutValid&&OutReady transfer.
module tb_mul_div_unit;

  logic clk;
  logic rst;

  mul_div_if #(.DATA_WIDTH(32)) bus ();

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, ubs;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ubs = longint'(ub);
    p   = '0;
    case (f3)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * ubs; return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Monitor: compare every transferred result against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.OutValid && bus.OutReady) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h required=none", bus.Result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("result f3=%0d a=%h b=%h", e.f3, e.a, e.b), bus.Result, e.res);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.InReady && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", 32'(bus.InReady), 32'd1);
  endtask

  // Issue one op, push its expectation, check latency and 1-cycle valid.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   lat;
    int   n;
    bit   seen;
    wait_ready();
    bus.Funct3  = f3;
    bus.Op1     = a;
    bus.Op2     = b;
    bus.InValid = 1'b1;
    e.res = model(f3, a, b);
    e.f3  = f3;
    e.a   = a;
    e.b   = b;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    bus.Op1     = $urandom();
    bus.Op2     = $urandom();
    seen = 1'b0;
    lat  = -1;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.OutValid) begin
        seen = 1'b1;
        lat  = n;
        break;
      end
    end
    chk($sformatf("latency f3=%0d", f3), 32'(lat), is_special(f3, a, b) ? 32'd1 : 32'd33);
    if (seen && bus.OutReady) begin
      @(posedge clk); #1;
      chk("valid_one_cycle", 32'(bus.OutValid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] held;
    bit          saw_valid;

    rst          = 1'b0;
    bus.Flush    = 1'b0;
    bus.InValid  = 1'b0;
    bus.Funct3   = 3'd0;
    bus.Op1      = '0;
    bus.Op2      = '0;
    bus.OutReady = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_inready",  32'(bus.InReady),  32'd0);
    chk("rst_outvalid", 32'(bus.OutValid), 32'd0);
    chk("rst_result",   bus.Result,        32'd0);
    chk("rst_busy",     32'(bus.Busy),     32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_inready", 32'(bus.InReady), 32'd1);
    @(posedge clk); #1;

    // Multiplies
    issue(3'd0, 32'd7,         32'hFFFF_FFFD);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Divides of -7 by 2
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'hFFFF_FFF9, 32'd2);
    issue(3'd7, 32'hFFFF_FFF9, 32'd2);

    // Special cases
    issue(3'd4, 32'h0000_1234, 32'd0);
    issue(3'd7, 32'h0000_1234, 32'd0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Back-pressure: hold the result for 10 cycles
    bus.OutReady = 1'b0;
    issue(3'd1, 32'h1234_5678, 32'hFEDC_BA98);
    held = bus.Result;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_result",   bus.Result,         held);
      chk("hold_outvalid", 32'(bus.OutValid),  32'd1);
      chk("hold_inready",  32'(bus.InReady),   32'd0);
      chk("hold_busy",     32'(bus.Busy),      32'd1);
    end
    bus.OutReady = 1'b1;
    @(posedge clk); #1;
    chk("after_xfer_inready",  32'(bus.InReady),  32'd1);
    chk("after_xfer_outvalid", 32'(bus.OutValid), 32'd0);
    issue(3'd4, 32'd100, 32'hFFFF_FFF9);

    // Flush during DIVU iteration 10
    wait_ready();
    bus.Funct3  = 3'd5;
    bus.Op1     = 32'hDEAD_BEEF;
    bus.Op2     = 32'd3;
    bus.InValid = 1'b1;
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.Flush = 1'b1;
    @(posedge clk); #1;
    bus.Flush = 1'b0;
    chk("flush_busy",    32'(bus.Busy),    32'd0);
    chk("flush_inready", 32'(bus.InReady), 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.OutValid) saw_valid = 1'b1;
    end
    chk("flush_no_outvalid", 32'(saw_valid), 32'd0);
    issue(3'd6, 32'd1000, 32'd7);

    // Reset mid-CALC
    wait_ready();
    bus.Funct3  = 3'd3;
    bus.Op1     = 32'hFFFF_FFFF;
    bus.Op2     = 32'hFFFF_FFFF;
    bus.InValid = 1'b1;
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_outvalid", 32'(bus.OutValid), 32'd0);
    chk("midrst_result",   bus.Result,        32'd0);
    chk("midrst_busy",     32'(bus.Busy),     32'd0);
    chk("midrst_inready",  32'(bus.InReady),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_release_inready", 32'(bus.InReady), 32'd1);
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), rand_op(), rand_op());
    end

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
